// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters (IDLE/EXEC/RESP).
// Optional `ALU_ARB_OPCHK_EN: illegal op codes bypass the ALU and answer with rsp_err=1.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32,
  parameter int OPW     = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_op,
  input  logic [NUM_REQ*DW-1:0]  req_a,
  input  logic [NUM_REQ*DW-1:0]  req_b,
  output logic [OPW-1:0]         alu_op,
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  input  logic [DW-1:0]          alu_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [DW-1:0]          rsp_data,
  output logic                   rsp_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]  last_q, last_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [DW-1:0]  data_q, data_d;
  logic           err_q, err_d;

  logic           lo_hit, hi_hit, found;
  logic [IW-1:0]  lo_sel, hi_sel, sel;
  logic [OPW-1:0] sel_op;
  logic [DW-1:0]  sel_a, sel_b;
  logic           sel_illegal;

  // Round-robin: lowest valid index above last wins, else wrap to the lowest valid index.
  always_comb begin
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    lo_sel = '0;
    hi_sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_hit = 1'b1;
        lo_sel = IW'(i);
      end
      if (req_valid[i] && (IW'(i) > last_q)) begin
        hi_hit = 1'b1;
        hi_sel = IW'(i);
      end
    end
    found = lo_hit;
    sel   = hi_hit ? hi_sel : lo_sel;
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IW'(i)) begin
        sel_op = req_op[i*OPW +: OPW];
        sel_a  = req_a[i*DW +: DW];
        sel_b  = req_b[i*DW +: DW];
      end
    end
`ifdef ALU_ARB_OPCHK_EN
    sel_illegal = !((sel_op <= OPW'(9)) || (sel_op == OPW'(13)));
`else
    sel_illegal = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        if (found && rst_n) begin
          for (int i = 0; i < NUM_REQ; i++) req_ready[i] = (sel == IW'(i));
          gnt_d = sel;
          if (sel_illegal) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        data_d  = alu_result;
        state_d = RESP;
      end
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = (gnt_q == IW'(i));
        for (int i = 0; i < NUM_REQ; i++) begin
          if ((gnt_q == IW'(i)) && rsp_ready[i]) begin
            last_d  = gnt_q;
            err_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign alu_op   = op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign rsp_data = data_q;
`ifdef ALU_ARB_OPCHK_EN
  assign rsp_err  = err_q;
`else
  assign rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural stand-in ALU.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int OPW     = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*OPW-1:0] req_op;
  logic [NUM_REQ*DW-1:0]  req_a;
  logic [NUM_REQ*DW-1:0]  req_b;
  logic [OPW-1:0]         alu_op;
  logic [DW-1:0]          alu_a;
  logic [DW-1:0]          alu_b;
  logic [DW-1:0]          alu_result;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_err;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; unknown op codes produce a recognisable marker value.
  always_comb begin
    case (alu_op)
      6'h00, 6'h06: alu_result = alu_a + alu_b;
      6'h01, 6'h08: alu_result = alu_a - alu_b;
      6'h02, 6'h07: alu_result = alu_a & alu_b;
      6'h03:        alu_result = ~(alu_a | alu_b);
      6'h04, 6'h09: alu_result = alu_a | alu_b;
      6'h05, 6'h0D: alu_result = {31'b0, (alu_a < alu_b)};
      default:      alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [OPW-1:0] op,
                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[idx]            = 1'b1;
    req_op[idx*OPW +: OPW]    = op;
    req_a[idx*DW +: DW]       = a;
    req_b[idx*DW +: DW]       = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 6'h00, 32'd100 + i, 32'd1);

    // Reset held with every requester valid
    #3;
    checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
    tick();
    tick();
    checkOutput("rst_alu_op", 64'(alu_op), 64'h0);
    checkOutput("rst_alu_a", 64'(alu_a), 64'h0);
    checkOutput("rst_alu_b", 64'(alu_b), 64'h0);
    checkOutput("rst_rsp_data", 64'(rsp_data), 64'h0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("first_grant", 64'(req_ready), 64'h1);
    req_valid = '0;
    tick();

    // Req0 ADD 5+7
    applyStimulus(0, 6'h00, 32'd5, 32'd7);
    rsp_ready = 4'b0001;
    #1;
    checkOutput("add_ready", 64'(req_ready), 64'h1);
    tick();
    checkOutput("add_alu_op", 64'(alu_op), 64'h0);
    checkOutput("add_alu_a", 64'(alu_a), 64'd5);
    checkOutput("add_alu_b", 64'(alu_b), 64'd7);
    checkOutput("add_exec_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("add_exec_ready", 64'(req_ready), 64'h0);
    req_valid = '0;
    tick();
    checkOutput("add_rsp_valid", 64'(rsp_valid), 64'h1);
    checkOutput("add_rsp_data", 64'(rsp_data), 64'd12);
    checkOutput("add_rsp_err", 64'(rsp_err), 64'h0);
    tick();
    checkOutput("add_done_valid", 64'(rsp_valid), 64'h0);
    checkOutput("add_done_data", 64'(rsp_data), 64'd12);

    // Fresh reset, then all four requesters contend
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_rsp_data", 64'(rsp_data), 64'h0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 6'h00, 32'(10 * i), 32'd1);
    rsp_ready = '1;
    #1;
    for (int g = 0; g < 6; g++) begin
      checkOutput($sformatf("rr_grant%0d", g), 64'(req_ready), 64'(1 << (g % 4)));
      tick();
      checkOutput($sformatf("rr_exec_ready%0d", g), 64'(req_ready), 64'h0);
      tick();
      checkOutput($sformatf("rr_rsp_valid%0d", g), 64'(rsp_valid), 64'(1 << (g % 4)));
      checkOutput($sformatf("rr_rsp_data%0d", g), 64'(rsp_data), 64'(10 * (g % 4) + 1));
      tick();
    end
    req_valid = '0;

    // Req2 SUB 0-1 with a stalled response
    applyStimulus(2, 6'h01, 32'd0, 32'd1);
    rsp_ready = '0;
    #1;
    checkOutput("sub_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b1011;
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("sub_hold_valid%0d", c), 64'(rsp_valid), 64'h4);
      checkOutput($sformatf("sub_hold_data%0d", c), 64'(rsp_data), 64'hFFFF_FFFF);
      checkOutput($sformatf("sub_hold_ready%0d", c), 64'(req_ready), 64'h0);
      rsp_ready = 4'b1011;
      tick();
    end
    rsp_ready = 4'b0100;
    #1;
    checkOutput("sub_release_ready", 64'(req_ready), 64'h0);
    tick();
    checkOutput("sub_done_valid", 64'(rsp_valid), 64'h0);
    checkOutput("sub_next_grant", 64'(req_ready), 64'h8);
    req_valid = '0;
    rsp_ready = '1;

    // Req1 SLTI, then an illegal op code
    applyStimulus(1, 6'h0D, 32'd3, 32'd9);
    #1;
    checkOutput("slti_grant", 64'(req_ready), 64'h2);
    tick();
    checkOutput("slti_alu_op", 64'(alu_op), 64'h0D);
    req_valid = '0;
    tick();
    checkOutput("slti_rsp_valid", 64'(rsp_valid), 64'h2);
    checkOutput("slti_rsp_data", 64'(rsp_data), 64'd1);
    checkOutput("slti_rsp_err", 64'(rsp_err), 64'h0);
    tick();
    applyStimulus(1, 6'h3F, 32'd8, 32'd4);
    #1;
    checkOutput("ill_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
`ifdef ALU_ARB_OPCHK_EN
    checkOutput("ill_rsp_valid", 64'(rsp_valid), 64'h2);
    checkOutput("ill_rsp_err", 64'(rsp_err), 64'h1);
    checkOutput("ill_rsp_data", 64'(rsp_data), 64'h0);
    checkOutput("ill_alu_op", 64'(alu_op), 64'h0D);
    checkOutput("ill_alu_a", 64'(alu_a), 64'd3);
    tick();
    checkOutput("ill_done_valid", 64'(rsp_valid), 64'h0);
    checkOutput("ill_done_err", 64'(rsp_err), 64'h0);
`else
    checkOutput("ill_exec_valid", 64'(rsp_valid), 64'h0);
    checkOutput("ill_alu_op", 64'(alu_op), 64'h3F);
    tick();
    checkOutput("ill_rsp_valid", 64'(rsp_valid), 64'h2);
    checkOutput("ill_rsp_err", 64'(rsp_err), 64'h0);
    checkOutput("ill_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
    tick();
    checkOutput("ill_done_valid", 64'(rsp_valid), 64'h0);
`endif

    // Reset asserted while a response is pending
    applyStimulus(3, 6'h04, 32'h0000_00F0, 32'h0000_000F);
    rsp_ready = '0;
    #1;
    checkOutput("mid_grant", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    tick();
    checkOutput("mid_rsp_valid", 64'(rsp_valid), 64'h8);
    checkOutput("mid_rsp_data", 64'(rsp_data), 64'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(rsp_valid), 64'h0);
    checkOutput("mid_rst_data", 64'(rsp_data), 64'h0);
    checkOutput("mid_rst_alu_op", 64'(alu_op), 64'h0);
    req_valid = 4'b0101;
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_grant", 64'(req_ready), 64'h1);
    tick();
    checkOutput("post_rst_alu_b", 64'(alu_b), 64'd1);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
